pvt_uart_rx: RTL
================

# pvt_uart_rx

Serial receive front end for the PVT sensor group wrappers: it synchronises the asynchronous `rx` pin, detects and validates start bits, and recovers 8N1 UART bytes using a 3-sample majority vote at each bit centre. Each good byte is presented on `data_out` with a single-cycle `out_valid` strobe, which feeds the address/data decode FSM of every sensor wrapper on the shared line. Stop-bit failures are reported on `frame_err` and never produce `out_valid`.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200). Legal range is at least 4.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `rx` input, 1 bit: asynchronous serial line, idle high.
- `out_valid` output, 1 bit: one-cycle strobe marking a good byte.
- `data_out` output, 8 bits: last good byte, held until the next good byte.
- `frame_err` output, 1 bit: one-cycle strobe when the stop bit samples low.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** two flops, both reset to 1. All logic uses the second-stage output `rx_s`.
- **Derived values:** `HALF = CLKS_PER_BIT/2`, rounded down. The bit-cycle counter `cnt` is sized with `$clog2(CLKS_PER_BIT)`. `bit_idx` is 3 bits.
- **IDLE:**
  - When `rx_s==0`, go to START with `cnt=0`.
  - Otherwise stay in IDLE.
- **START:**
  - `cnt` increments each cycle.
  - At `cnt==HALF-1`, sample `rx_s`.
  - If the sample is 1, the low was a glitch: return to IDLE with no output.
  - If the sample is 0, go to DATA with `cnt=0` and `bit_idx=0`.
- **DATA:**
  - `cnt` counts 0 to `CLKS_PER_BIT-1` and then wraps.
  - Capture `rx_s` at `cnt==CLKS_PER_BIT-3` and at `cnt==CLKS_PER_BIT-2`.
  - At `cnt==CLKS_PER_BIT-1`, form the majority of those two captures plus the current `rx_s`.
  - Shift the majority bit into the MSB of an 8-bit shift register (shift right, LSB first on the line).
  - Then increment `bit_idx`. After `bit_idx==7` is consumed, go to STOP with `cnt=0`.
- **STOP:**
  - The same 3-sample majority is taken at `cnt==CLKS_PER_BIT-1`.
  - Majority 1: pulse `out_valid`, load `data_out` with the shift register, go to IDLE.
  - Majority 0: pulse `frame_err`, leave `data_out` unchanged, go to BREAK.
- **BREAK:** stay until `rx_s==1`, then go to IDLE. A held-low line (break) therefore yields exactly one `frame_err` and nothing else.
- **Strobe exclusivity:** `out_valid` and `frame_err` are never high in the same cycle.
- **No host handshake:** a byte is never stalled or buffered. Consumers must sample on the `out_valid` cycle.

## Timing
- **Reset values:** `out_valid=0`, `frame_err=0`, `data_out=8'h00`, `busy=0`, FSM in IDLE, shift register 0, both synchroniser flops 1.
- **Strobe registration:** outputs are registered. `out_valid` / `frame_err` go high the cycle after the STOP decision cycle, for exactly 1 cycle.
- **Latency:** measure from the first clk edge where `rx` is low (pin) to `out_valid` high. Nominal value is 2 (synchroniser) + HALF + 9·CLKS_PER_BIT + 1 cycles. For `CLKS_PER_BIT=16` that is 155 cycles.
- **`busy` timing:** rises the cycle after `rx_s` first reads 0. Falls the cycle the FSM re-enters IDLE, which is the same cycle `out_valid` rises.
- **Back-to-back frames:**
  - IDLE is re-entered at the stop-bit centre, so a start bit immediately following a 1-bit stop is detected.
  - A new falling edge seen in the same cycle `out_valid` is high is accepted normally.
- **Reset mid-frame:** asynchronous return to all reset values. The partial byte is discarded, and no strobe is emitted after reset release.
- **Line glitches:** a single-cycle glitch at any one of the three sample points of a data or stop bit is outvoted by the majority. A glitch landing exactly on the start-bit sample point is not filtered.

## Test plan
- **Good byte:** `CLKS_PER_BIT=16`, send 0xA5 8N1 → exactly one `out_valid` 155 cycles after the falling edge, `data_out=0xA5`, `frame_err` never high, `busy` low afterwards.
- **Back-to-back:** send 0x00 then 0xFF back-to-back, with the next start bit right after the stop bit → two `out_valid` strobes 160 cycles apart, `data_out` 0x00 then 0xFF.
- **Start glitch:** hold `rx` low for 4 cycles, then high → `busy` pulses, then returns to IDLE; no `out_valid`, no `frame_err`, `data_out` unchanged.
- **Framing error / break:** send 0x3C with the stop bit forced low, and hold `rx` low for 40 more bit times → one `frame_err` pulse, `data_out` retains the previous value, `busy` stays high until `rx` returns high, then the next 0x5A frame is received correctly.
- **Majority filter:** send 0x81 with a 1-cycle inverted pulse on `rx` aligned to the `CLKS_PER_BIT-2` sample point of bit 3 → `data_out=0x81`.
- **Reset mid-frame:** assert `rst_n` low during bit 4 of a frame, release, then send 0x42 → no strobe for the aborted frame, then `data_out=0x42` with a single `out_valid`.

Source files
------------

// File: rtl/pvt_uart_rx.sv
// 8N1 UART receiver for the PVT sensor wrappers: two-flop synchroniser,
// start-bit validation and 3-sample majority vote at each bit centre.
module pvt_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       out_valid,
    output logic [7:0] data_out,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CAP1    = CW'(CLKS_PER_BIT - 3);
    localparam logic [CW-1:0] CAP2    = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic            rx_m;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            samp1;
    logic            samp2;
    logic            maj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Two early captures plus the live sample at the last cycle of the bit.
    assign maj  = (samp1 & samp2) | (samp1 & rx_s) | (samp2 & rx_s);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            samp1     <= 1'b1;
            samp2     <= 1'b1;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (state == S_DATA || state == S_STOP) begin
                if (cnt == CAP1) samp1 <= rx_s;
                if (cnt == CAP2) samp2 <= rx_s;
            end
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {maj, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (maj) begin
                            out_valid <= 1'b1;
                            data_out  <= shreg;
                            state     <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
